// File: rtl/pipe_pkg.sv
// Shared constants for the valid-tagged pipeline register chain: stage indices,
// default geometry and the occupancy counter width helper.
package pipe_pkg;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EXE = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  localparam int PIPE_DEPTH_DEFAULT = 5;
  localparam int PIPE_WIDTH_DEFAULT = 32;
  localparam int PIPE_CNT_W_DEFAULT = 16;

  // Bits needed to count 0..depth valid stages inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: a valid bit plus payload that loads when not held.
// Flush clears only the valid bit and wins over both load and hold.
module pipe_stage_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flush,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (!hold) begin
      valid_d = load_valid;
      data_d  = load_data;
    end
    if (flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/pipeline_reg_chain.sv
// Chain of DEPTH valid-tagged stage registers with upstream-propagating stalls,
// per-stage flush, sink handshake, occupancy and retired-entry counting.
module pipeline_reg_chain
  import pipe_pkg::*;
#(
  parameter int DEPTH = PIPE_DEPTH_DEFAULT,
  parameter int WIDTH = PIPE_WIDTH_DEFAULT,
  parameter int CNT_W = PIPE_CNT_W_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  input  logic [DEPTH-1:0]              stall_req,
  input  logic [DEPTH-1:0]              flush,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  output logic [DEPTH-1:0]              stage_valid,
  output logic [DEPTH*WIDTH-1:0]        stage_data,
  output logic [occ_width(DEPTH)-1:0]   occupancy,
  output logic [CNT_W-1:0]              retired_count
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] hold;
  logic [DEPTH-1:0] ld_valid;
  logic [WIDTH-1:0] ld_data [DEPTH];
  logic [DEPTH-1:0] stg_valid;
  logic [WIDTH-1:0] stg_data [DEPTH];
  logic             out_fire;
  logic [OCC_W-1:0] occ;
  logic [CNT_W-1:0] retired_d, retired_q;

  // A stall at stage i holds every stage at or below i; the sink's !out_ready
  // behaves as a stall beyond the last stage, even when that stage is empty.
  always_comb begin : hold_chain
    logic h;
    h    = ~out_ready;
    hold = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      h       = h | stall_req[i];
      hold[i] = h;
    end
  end

  // A stage that advances while its upstream neighbour is held takes a bubble;
  // the payload still copies so invalid stages stay deterministic.
  always_comb begin
    ld_valid         = '0;
    ld_valid[STG_IF] = in_valid;
    ld_data[STG_IF]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      ld_valid[i] = stg_valid[i-1] & ~hold[i-1];
      ld_data[i]  = stg_data[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipe_stage_reg #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .hold      (hold[g]),
      .flush     (flush[g]),
      .load_valid(ld_valid[g]),
      .load_data (ld_data[g]),
      .valid     (stg_valid[g]),
      .data      (stg_data[g])
    );
    assign stage_data[g*WIDTH +: WIDTH] = stg_data[g];
  end

  assign in_ready    = ~hold[STG_IF];
  assign stage_valid = stg_valid;
  assign out_valid   = stg_valid[DEPTH-1];
  assign out_data    = stg_data[DEPTH-1];

  // Handshake: an entry retires when the last stage is valid and the sink is
  // ready, unless the last stage itself is stalled; a same-cycle flush of the
  // last stage does not cancel it.
  assign out_fire = out_valid & out_ready & ~stall_req[DEPTH-1];

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + {{(OCC_W-1){1'b0}}, stg_valid[i]};
    end
  end

  assign occupancy = occ;

  always_comb begin
    retired_d = retired_q;
    if (out_fire) begin
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired_count = retired_q;

endmodule

// File: tb/tb_pipeline_reg_chain.sv
// Directed, table-driven bench for pipeline_reg_chain (DEPTH=5, WIDTH=32, CNT_W=4)
// plus hand-written sequences for flush payloads, counter wrap and async reset.
module tb_pipeline_reg_chain;

  localparam int DEPTH = 5;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;
  localparam logic [4:0] N5 = 5'b00000;

  typedef logic [DEPTH*WIDTH-1:0] cv_t;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic [4:0]  st;
    logic [4:0]  fl;
    logic        ordy;
    logic        eir;
    logic        eov;
    logic [31:0] eod;
    logic [4:0]  esv;
    logic [2:0]  eocc;
    logic [3:0]  eret;
  } vec_t;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic                   in_ready;
  logic [DEPTH-1:0]       stall_req;
  logic [DEPTH-1:0]       flush;
  logic                   out_ready;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic [DEPTH-1:0]       stage_valid;
  logic [DEPTH*WIDTH-1:0] stage_data;
  logic [2:0]             occupancy;
  logic [CNT_W-1:0]       retired_count;

  int   checks = 0;
  int   errors = 0;
  vec_t vq[$];

  pipeline_reg_chain #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .stall_req    (stall_req),
    .flush        (flush),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .stage_valid  (stage_valid),
    .stage_data   (stage_data),
    .occupancy    (occupancy),
    .retired_count(retired_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  task automatic check(input string name, input cv_t act, input cv_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    stall_req = '0;
    flush     = '0;
    out_ready = 1'b1;
    rst       = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // driver tasks
  task automatic row(input logic iv, input logic [31:0] id, input logic [4:0] st,
                     input logic [4:0] fl, input logic ordy, input logic eir,
                     input logic eov, input logic [31:0] eod, input logic [4:0] esv,
                     input logic [2:0] eocc, input logic [3:0] eret);
    vec_t v;
    v.iv = iv; v.id = id; v.st = st; v.fl = fl; v.ordy = ordy;
    v.eir = eir; v.eov = eov; v.eod = eod; v.esv = esv; v.eocc = eocc; v.eret = eret;
    vq.push_back(v);
  endtask

  task automatic run_vectors(input string tag);
    foreach (vq[i]) begin
      in_valid  = vq[i].iv;
      in_data   = vq[i].id;
      stall_req = vq[i].st;
      flush     = vq[i].fl;
      out_ready = vq[i].ordy;
      @(negedge clk);
      check($sformatf("%s[%0d].in_ready", tag, i), cv_t'(in_ready), cv_t'(vq[i].eir));
      check($sformatf("%s[%0d].out_valid", tag, i), cv_t'(out_valid), cv_t'(vq[i].eov));
      if (vq[i].eov)
        check($sformatf("%s[%0d].out_data", tag, i), cv_t'(out_data), cv_t'(vq[i].eod));
      check($sformatf("%s[%0d].stage_valid", tag, i), cv_t'(stage_valid), cv_t'(vq[i].esv));
      check($sformatf("%s[%0d].occupancy", tag, i), cv_t'(occupancy), cv_t'(vq[i].eocc));
      check($sformatf("%s[%0d].retired", tag, i), cv_t'(retired_count), cv_t'(vq[i].eret));
      @(posedge clk);
      #1;
    end
    vq.delete();
  endtask

  initial begin
    logic        found;
    int          lat;
    logic [31:0] sd [DEPTH];

    rst = 1'b1;
    do_reset();

    // free flow, 8 entries
    row(T, 32'h00, N5, N5, T,  T, F, 32'h00, 5'b00000, 3'd0, 4'd0);
    row(T, 32'h04, N5, N5, T,  T, F, 32'h00, 5'b00001, 3'd1, 4'd0);
    row(T, 32'h08, N5, N5, T,  T, F, 32'h00, 5'b00011, 3'd2, 4'd0);
    row(T, 32'h0C, N5, N5, T,  T, F, 32'h00, 5'b00111, 3'd3, 4'd0);
    row(T, 32'h10, N5, N5, T,  T, F, 32'h00, 5'b01111, 3'd4, 4'd0);
    row(T, 32'h14, N5, N5, T,  T, T, 32'h00, 5'b11111, 3'd5, 4'd0);
    row(T, 32'h18, N5, N5, T,  T, T, 32'h04, 5'b11111, 3'd5, 4'd1);
    row(T, 32'h1C, N5, N5, T,  T, T, 32'h08, 5'b11111, 3'd5, 4'd2);
    row(F, 32'h00, N5, N5, T,  T, T, 32'h0C, 5'b11111, 3'd5, 4'd3);
    row(F, 32'h00, N5, N5, T,  T, T, 32'h10, 5'b11110, 3'd4, 4'd4);
    row(F, 32'h00, N5, N5, T,  T, T, 32'h14, 5'b11100, 3'd3, 4'd5);
    row(F, 32'h00, N5, N5, T,  T, T, 32'h18, 5'b11000, 3'd2, 4'd6);
    row(F, 32'h00, N5, N5, T,  T, T, 32'h1C, 5'b10000, 3'd1, 4'd7);
    row(F, 32'h00, N5, N5, T,  T, F, 32'h00, 5'b00000, 3'd0, 4'd8);
    run_vectors("flow");

    // stall_req[2] for two cycles mid-stream
    do_reset();
    row(T, 32'h100, N5,       N5, T,  T, F, 32'h000, 5'b00000, 3'd0, 4'd0);
    row(T, 32'h104, N5,       N5, T,  T, F, 32'h000, 5'b00001, 3'd1, 4'd0);
    row(T, 32'h108, N5,       N5, T,  T, F, 32'h000, 5'b00011, 3'd2, 4'd0);
    row(T, 32'h10C, N5,       N5, T,  T, F, 32'h000, 5'b00111, 3'd3, 4'd0);
    row(T, 32'h110, 5'b00100, N5, T,  F, F, 32'h000, 5'b01111, 3'd4, 4'd0);
    row(T, 32'h110, 5'b00100, N5, T,  F, T, 32'h100, 5'b10111, 3'd4, 4'd0);
    row(T, 32'h110, N5,       N5, T,  T, F, 32'h000, 5'b00111, 3'd3, 4'd1);
    row(T, 32'h114, N5,       N5, T,  T, F, 32'h000, 5'b01111, 3'd4, 4'd1);
    row(T, 32'h118, N5,       N5, T,  T, T, 32'h104, 5'b11111, 3'd5, 4'd1);
    row(T, 32'h11C, N5,       N5, T,  T, T, 32'h108, 5'b11111, 3'd5, 4'd2);
    row(F, 32'h000, N5,       N5, T,  T, T, 32'h10C, 5'b11111, 3'd5, 4'd3);
    row(F, 32'h000, N5,       N5, T,  T, T, 32'h110, 5'b11110, 3'd4, 4'd4);
    row(F, 32'h000, N5,       N5, T,  T, T, 32'h114, 5'b11100, 3'd3, 4'd5);
    row(F, 32'h000, N5,       N5, T,  T, T, 32'h118, 5'b11000, 3'd2, 4'd6);
    row(F, 32'h000, N5,       N5, T,  T, T, 32'h11C, 5'b10000, 3'd1, 4'd7);
    row(F, 32'h000, N5,       N5, T,  T, F, 32'h000, 5'b00000, 3'd0, 4'd8);
    run_vectors("stall2");

    // full pipe, sink not ready for three cycles
    do_reset();
    row(T, 32'h200, N5, N5, T,  T, F, 32'h000, 5'b00000, 3'd0, 4'd0);
    row(T, 32'h204, N5, N5, T,  T, F, 32'h000, 5'b00001, 3'd1, 4'd0);
    row(T, 32'h208, N5, N5, T,  T, F, 32'h000, 5'b00011, 3'd2, 4'd0);
    row(T, 32'h20C, N5, N5, T,  T, F, 32'h000, 5'b00111, 3'd3, 4'd0);
    row(T, 32'h210, N5, N5, T,  T, F, 32'h000, 5'b01111, 3'd4, 4'd0);
    row(T, 32'h214, N5, N5, F,  F, T, 32'h200, 5'b11111, 3'd5, 4'd0);
    row(T, 32'h214, N5, N5, F,  F, T, 32'h200, 5'b11111, 3'd5, 4'd0);
    row(T, 32'h214, N5, N5, F,  F, T, 32'h200, 5'b11111, 3'd5, 4'd0);
    row(T, 32'h214, N5, N5, T,  T, T, 32'h200, 5'b11111, 3'd5, 4'd0);
    row(F, 32'h000, N5, N5, T,  T, T, 32'h204, 5'b11111, 3'd5, 4'd1);
    row(F, 32'h000, N5, N5, T,  T, T, 32'h208, 5'b11110, 3'd4, 4'd2);
    row(F, 32'h000, N5, N5, T,  T, T, 32'h20C, 5'b11100, 3'd3, 4'd3);
    row(F, 32'h000, N5, N5, T,  T, T, 32'h210, 5'b11000, 3'd2, 4'd4);
    row(F, 32'h000, N5, N5, T,  T, T, 32'h214, 5'b10000, 3'd1, 4'd5);
    row(F, 32'h000, N5, N5, T,  T, F, 32'h000, 5'b00000, 3'd0, 4'd6);
    run_vectors("backpr");

    // flush stages 0,1 while stage 1 stalls
    do_reset();
    row(T, 32'h300, N5,       N5,       T,  T, F, 32'h000, 5'b00000, 3'd0, 4'd0);
    row(T, 32'h304, N5,       N5,       T,  T, F, 32'h000, 5'b00001, 3'd1, 4'd0);
    row(T, 32'h308, N5,       N5,       T,  T, F, 32'h000, 5'b00011, 3'd2, 4'd0);
    row(T, 32'h30C, N5,       N5,       T,  T, F, 32'h000, 5'b00111, 3'd3, 4'd0);
    row(T, 32'h310, N5,       N5,       T,  T, F, 32'h000, 5'b01111, 3'd4, 4'd0);
    row(T, 32'h314, 5'b00010, 5'b00011, T,  F, T, 32'h300, 5'b11111, 3'd5, 4'd0);
    run_vectors("flush_a");
    for (int i = 0; i < DEPTH; i++) sd[i] = stage_data[i*WIDTH +: WIDTH];
    check("flush_pay_s0", cv_t'(sd[0]), cv_t'(32'h310));
    check("flush_pay_s1", cv_t'(sd[1]), cv_t'(32'h30C));
    check("flush_pay_s2", cv_t'(sd[2]), cv_t'(32'h30C));
    check("flush_pay_s3", cv_t'(sd[3]), cv_t'(32'h308));
    check("flush_pay_s4", cv_t'(sd[4]), cv_t'(32'h304));
    row(T, 32'h314, N5, N5, T,  T, T, 32'h304, 5'b11000, 3'd2, 4'd1);
    row(F, 32'h000, N5, N5, T,  T, T, 32'h308, 5'b10001, 3'd2, 4'd2);
    row(F, 32'h000, N5, N5, T,  T, F, 32'h000, 5'b00010, 3'd1, 4'd3);
    row(F, 32'h000, N5, N5, T,  T, F, 32'h000, 5'b00100, 3'd1, 4'd3);
    row(F, 32'h000, N5, N5, T,  T, F, 32'h000, 5'b01000, 3'd1, 4'd3);
    row(F, 32'h000, N5, N5, T,  T, T, 32'h314, 5'b10000, 3'd1, 4'd3);
    row(F, 32'h000, N5, N5, T,  T, F, 32'h000, 5'b00000, 3'd0, 4'd4);
    run_vectors("flush_b");

    // 17 handshakes wrap a 4-bit counter to 1
    do_reset();
    for (int k = 0; k < 17; k++) begin
      in_valid = 1'b1;
      in_data  = 32'(k);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("wrap_retired", cv_t'(retired_count), cv_t'(4'd1));
    check("wrap_occ", cv_t'(occupancy), cv_t'(3'd0));

    // empty pipe with sink not ready freezes input; output-stage stall blocks
    // retirement; flush of the output stage does not cancel a fire
    do_reset();
    out_ready = 1'b0;
    #1;
    check("freeze_in_ready", cv_t'(in_ready), cv_t'(1'b0));
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hABC;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    stall_req = 5'b10000;
    @(negedge clk);
    check("ostall_valid", cv_t'(out_valid), cv_t'(1'b1));
    check("ostall_in_ready", cv_t'(in_ready), cv_t'(1'b0));
    @(posedge clk);
    #1;
    stall_req = '0;
    check("ostall_hold_valid", cv_t'(out_valid), cv_t'(1'b1));
    check("ostall_hold_data", cv_t'(out_data), cv_t'(32'hABC));
    check("ostall_no_retire", cv_t'(retired_count), cv_t'(4'd0));
    flush = 5'b10000;
    @(posedge clk);
    #1;
    flush = '0;
    check("oflush_retired", cv_t'(retired_count), cv_t'(4'd1));
    check("oflush_valid", cv_t'(out_valid), cv_t'(1'b0));

    // asynchronous reset with a full pipe
    do_reset();
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h500 + 32'(4 * k);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("arst_pre_occ", cv_t'(occupancy), cv_t'(3'd5));
    check("arst_pre_retired", cv_t'(retired_count), cv_t'(4'd2));
    #2;
    rst = 1'b1;
    #1;
    check("arst_stage_valid", cv_t'(stage_valid), cv_t'(5'b00000));
    check("arst_out_valid", cv_t'(out_valid), cv_t'(1'b0));
    check("arst_retired", cv_t'(retired_count), cv_t'(4'd0));
    check("arst_occ", cv_t'(occupancy), cv_t'(3'd0));
    check("arst_stage_data", stage_data, cv_t'(0));
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h600;
    #1;
    check("arst_in_ready", cv_t'(in_ready), cv_t'(1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    found    = 1'b0;
    lat      = 0;
    for (int n = 1; n <= 20 && !found; n++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        lat   = n;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    check("arst_latency", cv_t'(lat), cv_t'(5));
    check("arst_first_data", cv_t'(out_data), cv_t'(32'h600));

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_reg_chain.md
Name: pipeline_reg_chain

Overview:
- Parametrised chain of DEPTH valid-tagged pipeline registers carrying a WIDTH-bit payload (PC or packed control) from fetch to writeback.
- Successor to the fixed 5-stage PC pass-through chain.
- Adds per-stage stall with upstream backpressure and bubble insertion, per-stage flush, and a sink-side ready handshake.
- Adds occupancy and retired-entry observability; it is the backbone on which stage logic is hung.

Parameters:
DEPTH, 5, number of register stages (>= 2); stage 0 = IF reg, stage DEPTH-1 = WB reg
WIDTH, 32, payload width per stage
CNT_W, 16, width of retired-entry counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  source has payload for stage 0
in_data  in  WIDTH  payload into stage 0
in_ready  out  1  stage 0 will load this cycle (= !hold[0])
stall_req  in  DEPTH  bit i: stage i must hold its contents this cycle
flush  in  DEPTH  bit i: value loaded or held in stage i this cycle is invalidated
out_ready  in  1  sink accepts stage DEPTH-1 contents
out_valid  out  1  valid bit of stage DEPTH-1
out_data  out  WIDTH  payload of stage DEPTH-1
stage_valid  out  DEPTH  valid bit of every stage
stage_data  out  DEPTH*WIDTH  payload of every stage, stage i at bits [i*WIDTH +: WIDTH]
occupancy  out  $clog2(DEPTH+1)  combinational popcount of stage_valid
retired_count  out  CNT_W  number of out_valid & out_ready handshakes, wraps

Behaviour:
- Reset (async, rst=1): all valid bits 0, all payloads 0, retired_count 0, at once without waiting for clk. in_ready follows its combinational definition. out_valid=0, occupancy=0.
- Hold chain, combinational:
  - hold[DEPTH-1] = stall_req[DEPTH-1] | !out_ready
  - hold[i] = stall_req[i] | hold[i+1]
  - Stalls propagate upstream only.
  - No bubble squashing: a held stage holds even if downstream is empty.
- Advance: stage i loads when !hold[i].
  - Stage 0 loads {in_valid, in_data}.
  - Stage i>0 loads {valid[i-1] & !hold[i-1], data[i-1]}.
  - When stage i-1 is held but stage i is not, stage i receives a bubble (valid 0). Payload still copies; payload of invalid stages is don't-care but deterministic.
- Hold: stage i keeps valid and payload when hold[i].
- Flush: flush[i] forces next valid[i]=0 whether stage i loads or holds.
  - Flush has priority over hold.
  - Payload is unaffected by flush.
  - Flushing a stage does not stall or flush any other stage.
- Input accepted iff in_valid & in_ready. If in_ready=1 and in_valid=0, stage 0 becomes a bubble.
- Output handshake: out_fire = out_valid & out_ready & !stall_req[DEPTH-1].
  - retired_count increments by 1 on out_fire, modulo 2^CNT_W.
  - A flush[DEPTH-1] in the same cycle does not cancel the current fire.
- Latency: with no stalls, a payload accepted at edge k appears on out_data after edge k+DEPTH-1, i.e. DEPTH cycles after presentation.
- Throughput: 1 entry per cycle when unstalled.
- Simultaneous stall_req on several stages: equivalent to the stall at the highest index plus holds below it. Bubbles are inserted only downstream of the highest stalled stage, i.e. only where hold[i-1]=1 and hold[i]=0.
- out_ready=0 with an empty last stage still holds the whole chain (freeze semantics by design).
- All outputs except the registered state are purely combinational from registers and current inputs; there is no combinational path from in_data to out_data.

Decomposition:
- Shared package pipe_pkg:
  - stage index constants STG_IF=0, STG_ID=1, STG_EXE=2, STG_MEM=3, STG_WB=4
  - default DEPTH/WIDTH constants
  - function for the occupancy popcount width
- One sub-module, pipe_stage_reg: one stage's valid+payload register with load, hold and flush inputs and async reset. pipeline_reg_chain instantiates it DEPTH times in a generate loop and owns the hold chain, handshake and counter logic.

Test Plan:
1. Free flow, DEPTH=5, WIDTH=32, out_ready=1, no stalls/flushes; feed in_data 0x0,0x4,...,0x1C with in_valid=1 -> out_valid first high 5 cycles after first accept with out_data=0x0; then 0x4..0x1C consecutive; retired_count=8; occupancy returns to 0.
2. stall_req[2]=1 for 2 cycles mid-stream -> in_ready=0 for those cycles, stages 0-2 unchanged; stage 3 receives 2 bubbles; output shows a 2-cycle valid gap with no duplicated or lost PC.
3. Pipe full, out_ready=0 for 3 cycles -> all stages held, in_ready=0, occupancy=5, out_data stable; release -> resumes with no loss; retired_count increments only on out_valid&out_ready.
4. flush=5'b00011 together with stall_req[1]=1 -> stage 0 and 1 valid=0 next cycle despite the hold, stage 2 gets a bubble; stages 3-4 advance normally; occupancy drops accordingly.
5. CNT_W=4, 17 handshakes -> retired_count=1 (wrap).
6. Assert rst asynchronously between edges with occupancy=5 -> stage_valid=0, out_valid=0, retired_count=0 before the next clk edge; first accepted payload after release appears after DEPTH cycles.
